// File: rtl/dec_pkg.sv
// Shared types and helpers for the streaming 2-to-4 decoder.
package dec_pkg;

  localparam int CODE_W   = 2;
  localparam int ONEHOT_W = 4;

  // FIFO occupancy doubles as the FSM state
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  function automatic logic [ONEHOT_W-1:0] bin2onehot(input logic [CODE_W-1:0] y);
    return ONEHOT_W'(1) << y;
  endfunction

endpackage

// File: rtl/onehot_dec_2x4.sv
// Combinational decode of a validated 2-bit code into a one-hot nibble.
module onehot_dec_2x4
  import dec_pkg::*;
(
  input  logic                v,
  input  logic [CODE_W-1:0]   y,
  output logic [ONEHOT_W-1:0] d,
  output logic                nv
);

  assign d  = v ? bin2onehot(y) : '0;
  assign nv = ~v;

endmodule

// File: rtl/decoder_2x4_stream.sv
// Valid/ready 2-to-4 decoder with a 2-entry output FIFO and a saturating
// counter of codes received without their validation bit.
module decoder_2x4_stream
  import dec_pkg::*;
#(
  parameter int CNT_W = 8
)
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_v,
  input  logic [CODE_W-1:0]   in_y,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ONEHOT_W-1:0] out_d,
  output logic                out_nv,
  output logic [CNT_W-1:0]    inv_cnt
);

  localparam int WORD_W = ONEHOT_W + 1;

  state_e              state_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                wr_ptr_q;
  logic                rd_ptr_q;
  logic [WORD_W-1:0]   mem_q [2];
  logic [CNT_W-1:0]    inv_cnt_q;
  logic [ONEHOT_W-1:0] dec_d;
  logic                dec_nv;
  logic                push;
  logic                pop;

  onehot_dec_2x4 u_dec (
    .v  (in_v),
    .y  (in_y),
    .d  (dec_d),
    .nv (dec_nv)
  );

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid_q && out_ready;

  // Handshake flags are registered alongside the state so in_ready never sees out_ready
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_q     <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (push && !pop) begin
            state_q    <= FULL;
            in_ready_q <= 1'b0;
          end else if (!push && pop) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        FULL: begin
          if (pop) begin
            state_q    <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      inv_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      if (push && dec_nv && (inv_cnt_q != {CNT_W{1'b1}}))
        inv_cnt_q <= inv_cnt_q + CNT_W'(1);
    end
  end

  // Storage carries no reset; the output mux below masks it while empty
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= {dec_nv, dec_d};
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_d     = out_valid_q ? mem_q[rd_ptr_q][ONEHOT_W-1:0] : '0;
  assign out_nv    = out_valid_q ? mem_q[rd_ptr_q][ONEHOT_W]     : 1'b0;
  assign inv_cnt   = inv_cnt_q;

endmodule
